// File: rtl/rf_ctrl_pkg.sv
// Shared encodings and default widths for the register-file access controller.
package rf_ctrl_pkg;

  localparam int DATA_W_DEF = 2;
  localparam int ADDR_W_DEF = 1;

  typedef enum logic [1:0] {
    OP_MOV = 2'b00,
    OP_ADD = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } rf_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_RESP  = 2'b11
  } rf_state_e;

endpackage

// File: rtl/rf_alu.sv
// Combinational operation unit: MOV/ADD/AND/XOR with carry-out from ADD only.
module rf_alu
  import rf_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  rf_op_e            op,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum    = {1'b0, op1} + {1'b0, op2};
    result = op1;
    carry  = 1'b0;
    case (op)
      OP_MOV: result = op1;
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      OP_AND: result = op1 & op2;
      OP_XOR: result = op1 ^ op2;
      default: result = op1;
    endcase
  end

endmodule

// File: rtl/rf_access_ctrl.sv
// Sequences one register-file command at a time: capture, read operands,
// write result, then hold the response until it is taken.
module rf_access_ctrl
  import rf_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  // valid/ready: a transfer happens on a rising edge where both are high;
  // the sender holds its payload stable while valid is high and ready is low.
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_src1,
  input  logic [ADDR_W-1:0] cmd_src2,
  input  logic [ADDR_W-1:0] cmd_dst,
  output logic [ADDR_W-1:0] rf_rd_addr1,
  output logic [ADDR_W-1:0] rf_rd_addr2,
  input  logic [DATA_W-1:0] rf_rd_data1,
  input  logic [DATA_W-1:0] rf_rd_data2,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              rf_wr_en,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_carry,
  output rf_state_e         dbg_state
);

  rf_state_e         state_q, state_d;
  rf_op_e            op_q;
  logic [ADDR_W-1:0] src1_q, src2_q, dst_q;
  logic [DATA_W-1:0] op1_q, op2_q, rsp_data_q;
  logic              rsp_carry_q;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;

  rf_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op_q),
    .op1    (op1_q),
    .op2    (op2_q),
    .result (alu_result),
    .carry  (alu_carry)
  );

  // Operands are latched before the write, so dst may alias either source.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_MOV;
      src1_q      <= '0;
      src2_q      <= '0;
      dst_q       <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && cmd_valid) begin
        op_q   <= rf_op_e'(cmd_op);
        src1_q <= cmd_src1;
        src2_q <= cmd_src2;
        dst_q  <= cmd_dst;
      end
      if (state_q == ST_READ) begin
        op1_q <= rf_rd_data1;
        op2_q <= rf_rd_data2;
      end
      if (state_q == ST_WRITE) begin
        rsp_data_q  <= alu_result;
        rsp_carry_q <= alu_carry;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_ready   = 1'b0;
    rf_rd_addr1 = '0;
    rf_rd_addr2 = '0;
    rf_wr_addr  = '0;
    rf_wr_data  = '0;
    rf_wr_en    = 1'b0;
    rsp_valid   = 1'b0;
    rsp_data    = '0;
    rsp_carry   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = ST_READ;
      end
      ST_READ: begin
        rf_rd_addr1 = src1_q;
        rf_rd_addr2 = src2_q;
        state_d     = ST_WRITE;
      end
      ST_WRITE: begin
        rf_wr_en   = 1'b1;
        rf_wr_addr = dst_q;
        rf_wr_data = alu_result;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_data  = rsp_data_q;
        rsp_carry = rsp_carry_q;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Bench for rf_access_ctrl: directed scenarios plus random commands against
// a register-file reference model.
module tb_rf_access_ctrl;
  import rf_ctrl_pkg::*;

  localparam int DATA_W = 2;
  localparam int ADDR_W = 1;
  localparam int NREG   = 1 << ADDR_W;

  logic              clk;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_src1, cmd_src2, cmd_dst;
  logic [ADDR_W-1:0] rf_rd_addr1, rf_rd_addr2, rf_wr_addr;
  logic [DATA_W-1:0] rf_rd_data1, rf_rd_data2, rf_wr_data;
  logic              rf_wr_en;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_carry;
  rf_state_e         dbg_state;

  rf_access_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_src1    (cmd_src1),
    .cmd_src2    (cmd_src2),
    .cmd_dst     (cmd_dst),
    .rf_rd_addr1 (rf_rd_addr1),
    .rf_rd_addr2 (rf_rd_addr2),
    .rf_rd_data1 (rf_rd_data1),
    .rf_rd_data2 (rf_rd_data2),
    .rf_wr_addr  (rf_wr_addr),
    .rf_wr_data  (rf_wr_data),
    .rf_wr_en    (rf_wr_en),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_carry   (rsp_carry),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- register file attached to the DUT ----------------
  logic [DATA_W-1:0] mem [NREG];
  int wr_cnt = 0;
  assign rf_rd_data1 = mem[rf_rd_addr1];
  assign rf_rd_data2 = mem[rf_rd_addr2];
  always @(posedge clk) begin
    if (rf_wr_en) begin
      mem[rf_wr_addr] <= rf_wr_data;
      wr_cnt = wr_cnt + 1;
    end
  end

  // ---------------- reference model / scoreboard ----------------
  int ref_rf [NREG];
  logic [DATA_W:0] exp_q[$];   // {carry, data} per expected response
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Plain-arithmetic view of each operation.
  task automatic model_op(input int op, input int a, input int b, output int res, output int cy);
    int s;
    int m;
    m  = 1 << DATA_W;
    cy = 0;
    case (op)
      0: res = a;
      1: begin s = a + b; res = s % m; cy = s / m; end
      2: res = a & b;
      default: res = a ^ b;
    endcase
  endtask

  task automatic check_rf(input string tag);
    for (int i = 0; i < NREG; i++) check(tag, 32'(mem[i]), 32'(ref_rf[i]));
  endtask

  task automatic drive_idle_noise();
    cmd_op   = 2'($urandom_range(0, 3));
    cmd_src1 = ADDR_W'($urandom_range(0, NREG - 1));
    cmd_src2 = ADDR_W'($urandom_range(0, NREG - 1));
    cmd_dst  = ADDR_W'($urandom_range(0, NREG - 1));
  endtask

  // ---------------- driver ----------------
  // Runs one full command; stall = number of cycles rsp_ready stays low in RESP.
  task automatic run_cmd(input int op, input int s1, input int s2, input int d,
                         input int stall, input bit busy_cmd);
    int res, cy, w0, guard;
    logic [DATA_W:0] e;
    logic [DATA_W-1:0] held;
    model_op(op, ref_rf[s1], ref_rf[s2], res, cy);
    exp_q.push_back({1'(cy), DATA_W'(res)});
    guard = 0;
    while (!cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
      return;
    end
    w0 = wr_cnt;
    cmd_valid = 1'b1;
    cmd_op    = 2'(op);
    cmd_src1  = ADDR_W'(s1);
    cmd_src2  = ADDR_W'(s2);
    cmd_dst   = ADDR_W'(d);
    rsp_ready = 1'b0;
    @(posedge clk);                     // edge N: accepted
    @(negedge clk);
    cmd_valid = busy_cmd | 1'($urandom_range(0, 1));
    drive_idle_noise();
    check("read_cmd_ready", 32'(cmd_ready), 32'd0);
    check("read_addr1", 32'(rf_rd_addr1), 32'(s1));
    check("read_addr2", 32'(rf_rd_addr2), 32'(s2));
    check("read_no_wr", 32'(rf_wr_en), 32'd0);
    @(negedge clk);                     // after edge N+1: write cycle
    check("wr_en", 32'(rf_wr_en), 32'd1);
    check("wr_addr", 32'(rf_wr_addr), 32'(d));
    check("wr_data", 32'(rf_wr_data), 32'(res));
    check("wr_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);                     // after edge N+2: response
    ref_rf[d] = res;
    e = exp_q.pop_front();
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_data", 32'(rsp_data), 32'(e[DATA_W-1:0]));
    check("rsp_carry", 32'(rsp_carry), 32'(e[DATA_W]));
    held = rsp_data;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_data", 32'(rsp_data), 32'(held));
      check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    check("post_rsp_valid", 32'(rsp_valid), 32'd0);
    check("post_cmd_ready", 32'(cmd_ready), 32'd1);
    check("wr_pulse_count", 32'(wr_cnt - w0), 32'd1);
    check_rf("rf_contents");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int w0;
    reset     = 1'b0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    cmd_op    = '0;
    cmd_src1  = '0;
    cmd_src2  = '0;
    cmd_dst   = '0;
    mem[0] = 2'b01; ref_rf[0] = 1;
    mem[1] = 2'b10; ref_rf[1] = 2;
    repeat (2) @(negedge clk);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_wr_en", 32'(rf_wr_en), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // ADD R0+R1 -> R0 = 11, carry 0
    run_cmd(1, 0, 1, 0, 0, 1'b0);
    // MOV R0 -> R1 = 11, then ADD wraps to 10 with carry
    run_cmd(0, 0, 0, 1, 1, 1'b0);
    run_cmd(1, 0, 1, 1, 0, 1'b0);
    // XOR with dst aliasing both sources: R1 = 00
    run_cmd(3, 1, 1, 1, 0, 1'b0);
    // Response held back five cycles while a command is offered
    run_cmd(2, 0, 1, 0, 5, 1'b1);

    // Reset while in READ drops the command
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'd1;
    cmd_src1  = '0;
    cmd_src2  = '1;
    cmd_dst   = '0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("pre_rst_read", 32'(dbg_state), 32'(ST_READ));
    w0 = wr_cnt;
    reset = 1'b0;
    #1;
    check("async_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("async_rst_wr_en", 32'(rf_wr_en), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    end
    check("post_rst_no_write", 32'(wr_cnt - w0), 32'd0);
    check_rf("post_rst_rf");

    // Randomized commands
    for (int n = 0; n < 40; n++) begin
      run_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, NREG - 1)),
              int'($urandom_range(0, NREG - 1)), int'($urandom_range(0, NREG - 1)),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rf_access_ctrl.md
RF_ACCESS_CTRL -- requirements
Module: rf_access_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 2, register-file word width.
REQ-002 SHALL have parameter ADDR_W, default 1, register-file address width.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port cmd_valid, input, 1, command offered.
REQ-006 SHALL have port cmd_ready, output, 1, controller accepts command.
REQ-007 SHALL have port cmd_op, input, 2, operation: 00 MOV, 01 ADD, 10 AND, 11 XOR.
REQ-008 SHALL have ports cmd_src1, cmd_src2, cmd_dst, input, ADDR_W each, operand and destination addresses.
REQ-009 SHALL have port rf_rd_addr1 / rf_rd_addr2, output, ADDR_W each, register-file read addresses.
REQ-010 SHALL have port rf_rd_data1 / rf_rd_data2, input, DATA_W each, combinational read data from the register file.
REQ-011 SHALL have ports rf_wr_addr (ADDR_W), rf_wr_data (DATA_W), rf_wr_en (1), output, synchronous write port to the register file.
REQ-012 SHALL have ports rsp_valid (1) output, rsp_ready (1) input, rsp_data (DATA_W) output, rsp_carry (1) output, result response.

Function
REQ-013 SHALL implement FSM states IDLE, READ, WRITE, RESP; encoding binary.
REQ-014 SHALL assert cmd_ready only in IDLE; handshake = cmd_valid && cmd_ready at rising edge; op, src1, src2, dst captured into registers; IDLE->READ.
REQ-015 SHALL in READ drive rf_rd_addr1/2 from captured src1/src2 and register rf_rd_data1/2 at the end of the cycle; READ->WRITE unconditionally.
REQ-016 SHALL in WRITE assert rf_wr_en for exactly one cycle with rf_wr_addr = captured dst and rf_wr_data = result; WRITE->RESP.
REQ-017 SHALL compute result: MOV = op1; ADD = (op1 + op2) mod 2^DATA_W with carry = bit DATA_W of the sum; AND = op1 & op2; XOR = op1 ^ op2; carry = 0 for non-ADD.
REQ-018 SHALL in RESP hold rsp_valid = 1 with stable rsp_data/rsp_carry until rsp_ready = 1 at a rising edge; then RESP->IDLE.
REQ-019 SHALL give fixed latency: command accepted at edge N, write committed at edge N+2, rsp_valid high from cycle after edge N+2; next cmd_ready earliest in cycle after response handshake.
REQ-020 SHALL hold rf_wr_en = 0 in all states except WRITE; rf_rd_addr outputs = 0 outside READ.
REQ-021 SHALL handle dst equal to src1 or src2 correctly, since operands are registered before the write.
REQ-022 SHALL tolerate rsp_ready stalled indefinitely; no new command accepted and no extra write issued.
REQ-023 SHALL ignore cmd_* inputs when cmd_ready = 0.

Reset
REQ-024 SHALL on reset = 0, asynchronously force state IDLE, cmd_ready = 1 after deassertion, rsp_valid = 0, rsp_data = 0, rsp_carry = 0, rf_wr_en = 0, all address/data outputs = 0, captured registers = 0.
REQ-025 SHALL drop any in-flight command on reset mid-operation; no write and no response for it after deassertion.

Structure
REQ-026 SHALL place op encodings (MOV/ADD/AND/XOR), FSM state encodings, and DATA_W/ADDR_W defaults in a shared package rf_ctrl_pkg.
REQ-027 SHALL factor the operation logic into one combinational sub-module rf_alu (op, op1, op2 -> result, carry); FSM and registers stay in rf_access_ctrl.

Verification
REQ-028 SHALL cover: init R0=01, R1=10 via MOV path; cmd ADD src1=0 src2=1 dst=0 -> rf_wr_en one cycle at edge N+2, R0=11, rsp_data=11, rsp_carry=0.
REQ-029 SHALL cover: R0=11, R1=11, ADD dst=1 -> R1=10, rsp_carry=1 (wrap-around).
REQ-030 SHALL cover: XOR src1=1 src2=1 dst=1 with R1=10 -> R1=00, rsp_data=00 (dst aliases both sources).
REQ-031 SHALL cover: rsp_ready held 0 for 5 cycles with cmd_valid=1 -> rsp_valid and rsp_data stable, cmd_ready=0, rf_wr_en pulsed exactly once.
REQ-032 SHALL cover: reset asserted in READ state -> after deassertion no rf_wr_en pulse, rsp_valid=0, cmd_ready=1, register file unchanged.
